// File: rtl/clint_mc.sv
// clint_mc: multi-hart core-local interruptor (mtime, mtimecmp[], msip[]) behind a valid/ready register port.
// Define CLINT_RTC_EN to advance mtime from the external rtc_i strobe instead of the internal prescaler.
module clint_mc #(
    parameter int NR_CORES   = 1,
    parameter int ADDR_WIDTH = 16,
    parameter int PRESCALE   = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic [ADDR_WIDTH-1:0] req_addr_i,
    input  logic                  req_we_i,
    input  logic [63:0]           req_wdata_i,
    input  logic [7:0]            req_be_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [63:0]           rsp_rdata_o,
    output logic                  rsp_err_o,
    output logic [NR_CORES-1:0]   timer_irq_o,
    output logic [NR_CORES-1:0]   ipi_o
`ifdef CLINT_RTC_EN
    ,
    input  logic                  rtc_i
`endif
);

    localparam int WW = ADDR_WIDTH - 3;
    localparam logic [WW-1:0] CMP_WORD   = WW'(32'h0800);
    localparam logic [WW-1:0] MTIME_WORD = WW'(32'h17FF);

    typedef enum logic {IDLE, RESP} state_t;

    state_t              state_q;
    logic [63:0]         mtime_q;
    logic [63:0]         mtime_d;
    logic [63:0]         mtimecmp_q [NR_CORES];
    logic [63:0]         mtimecmp_d [NR_CORES];
    logic [NR_CORES-1:0] msip_q;
    logic [NR_CORES-1:0] msip_d;
    logic [NR_CORES-1:0] irq_d;
    logic [NR_CORES-1:0] msip_sel;
    logic [NR_CORES-1:0] cmp_sel;
    logic [WW-1:0]       word;
    logic                hit_mtime;
    logic                hit_err;
    logic                accept;
    logic                wr;
    logic                mtime_wr;
    logic                tick;
    logic [63:0]         rd_data;
    logic                unused_bits;

    function automatic logic [63:0] be_merge(input logic [63:0] old_v,
                                             input logic [63:0] new_v,
                                             input logic [7:0]  be);
        logic [63:0] r;
        for (int b = 0; b < 8; b++) begin
            r[b*8 +: 8] = be[b] ? new_v[b*8 +: 8] : old_v[b*8 +: 8];
        end
        return r;
    endfunction

    assign word     = req_addr_i[ADDR_WIDTH-1:3];
    assign accept   = req_valid_i && (state_q == IDLE);
    assign wr       = accept && req_we_i;
    assign mtime_wr = wr && hit_mtime && (req_be_i != 8'h00);
    assign ipi_o    = msip_q;

`ifdef CLINT_RTC_EN
    logic rtc_p0;
    logic rtc_p1;
    logic rtc_p2;

    // rtc_p0/rtc_p1 synchronise the asynchronous strobe; rtc_p2 holds the previous level for edge detection
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rtc_p0 <= 1'b0;
            rtc_p1 <= 1'b0;
            rtc_p2 <= 1'b0;
        end else begin
            rtc_p0 <= rtc_i;
            rtc_p1 <= rtc_p0;
            rtc_p2 <= rtc_p1;
        end
    end

    assign tick        = rtc_p1 & ~rtc_p2;
    assign unused_bits = ^{req_addr_i[2:0], 16'(PRESCALE)};
`else
    logic [15:0] presc_q;

    assign tick = (presc_q == 16'(PRESCALE - 1));

    // An mtime write restarts the prescaler so the next tick is a full period away
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            presc_q <= 16'd0;
        end else if (mtime_wr || tick) begin
            presc_q <= 16'd0;
        end else begin
            presc_q <= presc_q + 16'd1;
        end
    end

    assign unused_bits = ^req_addr_i[2:0];
`endif

    always_comb begin
        msip_sel = '0;
        cmp_sel  = '0;
        for (int i = 0; i < NR_CORES; i++) begin
            msip_sel[i] = (word == WW'(i));
            cmp_sel[i]  = (word == CMP_WORD + WW'(i));
        end
        hit_mtime = (word == MTIME_WORD);
        hit_err   = !((|msip_sel) || (|cmp_sel) || hit_mtime);
    end

    always_comb begin
        rd_data = 64'd0;
        for (int i = 0; i < NR_CORES; i++) begin
            if (msip_sel[i]) rd_data = {63'd0, msip_q[i]};
            if (cmp_sel[i])  rd_data = mtimecmp_q[i];
        end
        if (hit_mtime) rd_data = mtime_q;
    end

    // The irq compare uses the post-update values so the flop reflects this edge's writes and tick
    always_comb begin
        if (mtime_wr) begin
            mtime_d = be_merge(mtime_q, req_wdata_i, req_be_i);
        end else if (tick) begin
            mtime_d = mtime_q + 64'd1;
        end else begin
            mtime_d = mtime_q;
        end
        msip_d = msip_q;
        irq_d  = '0;
        for (int i = 0; i < NR_CORES; i++) begin
            mtimecmp_d[i] = (wr && cmp_sel[i]) ? be_merge(mtimecmp_q[i], req_wdata_i, req_be_i)
                                               : mtimecmp_q[i];
            if (wr && msip_sel[i] && req_be_i[0]) msip_d[i] = req_wdata_i[0];
            irq_d[i] = (mtime_d >= mtimecmp_d[i]);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mtime_q     <= 64'd0;
            msip_q      <= '0;
            timer_irq_o <= '0;
            for (int i = 0; i < NR_CORES; i++) mtimecmp_q[i] <= '1;
        end else begin
            mtime_q     <= mtime_d;
            msip_q      <= msip_d;
            timer_irq_o <= irq_d;
            for (int i = 0; i < NR_CORES; i++) mtimecmp_q[i] <= mtimecmp_d[i];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            req_ready_o <= 1'b1;
            rsp_valid_o <= 1'b0;
            rsp_rdata_o <= 64'd0;
            rsp_err_o   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        state_q     <= RESP;
                        req_ready_o <= 1'b0;
                        rsp_valid_o <= 1'b1;
                        rsp_rdata_o <= req_we_i ? 64'd0 : rd_data;
                        rsp_err_o   <= hit_err;
                    end
                end
                RESP: begin
                    if (rsp_ready_i) begin
                        state_q     <= IDLE;
                        req_ready_o <= 1'b1;
                        rsp_valid_o <= 1'b0;
                        rsp_rdata_o <= 64'd0;
                        rsp_err_o   <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    req_ready_o <= 1'b1;
                    rsp_valid_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_clint_mc.sv
// Bench for clint_mc (4 harts, PRESCALE 2): directed scenarios plus random register traffic against a time-based model.
module tb_clint_mc;

    localparam int NC = 4;
    localparam int P  = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic [15:0]   req_addr;
    logic          req_we;
    logic [63:0]   req_wdata;
    logic [7:0]    req_be;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [63:0]   rsp_rdata;
    logic          rsp_err;
    logic [NC-1:0] timer_irq;
    logic [NC-1:0] ipi;
    logic          rtc;

    int     checks = 0;
    int     errors = 0;
    longint cyc    = 0;

    // Model: mtime is the last written/reset value plus whole prescale periods elapsed since then
    logic [63:0] m_base;
    longint      m_bedge;
    logic [63:0] m_cmp [NC];
    logic        m_msip [NC];

    clint_mc #(.NR_CORES(NC), .ADDR_WIDTH(16), .PRESCALE(P)) dut (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_addr_i(req_addr),
        .req_we_i(req_we), .req_wdata_i(req_wdata), .req_be_i(req_be),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_rdata_o(rsp_rdata),
        .rsp_err_o(rsp_err), .timer_irq_o(timer_irq), .ipi_o(ipi)
`ifdef CLINT_RTC_EN
        , .rtc_i(rtc)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    function automatic logic [63:0] mt_pre(input longint e);
        if (e <= m_bedge) return m_base;
`ifdef CLINT_RTC_EN
        return m_base;
`else
        return m_base + 64'((e - m_bedge - 1) / P);
`endif
    endfunction

    function automatic logic [NC-1:0] irq_exp(input longint e);
        logic [NC-1:0] r;
        for (int i = 0; i < NC; i++) r[i] = (mt_pre(e + 1) >= m_cmp[i]);
        return r;
    endfunction

    function automatic logic [NC-1:0] ipi_exp();
        logic [NC-1:0] r;
        for (int i = 0; i < NC; i++) r[i] = m_msip[i];
        return r;
    endfunction

    function automatic logic [63:0] merge(input logic [63:0] o, input logic [63:0] n, input logic [7:0] be);
        logic [63:0] r;
        for (int b = 0; b < 8; b++) r[b*8 +: 8] = be[b] ? n[b*8 +: 8] : o[b*8 +: 8];
        return r;
    endfunction

    function automatic void model_reset(input longint e);
        m_base  = 64'd0;
        m_bedge = e;
        for (int i = 0; i < NC; i++) begin
            m_cmp[i]  = '1;
            m_msip[i] = 1'b0;
        end
    endfunction

    function automatic void model_txn(input logic [15:0] addr, input logic we, input logic [63:0] w,
                                      input logic [7:0] be, input longint acc,
                                      output logic [63:0] rd, output logic err);
        int a;
        a   = int'(addr) & ~7;
        rd  = 64'd0;
        err = 1'b0;
        if (a < 8 * NC) begin
            if (!we) rd = {63'd0, m_msip[a / 8]};
            else if (be[0]) m_msip[a / 8] = w[0];
        end else if (a >= 'h4000 && a < 'h4000 + 8 * NC) begin
            if (!we) rd = m_cmp[(a - 'h4000) / 8];
            else m_cmp[(a - 'h4000) / 8] = merge(m_cmp[(a - 'h4000) / 8], w, be);
        end else if (a == 'hBFF8) begin
            if (!we) rd = mt_pre(acc);
            else if (be != 8'h00) begin
                m_base  = merge(mt_pre(acc), w, be);
                m_bedge = acc;
            end
        end else begin
            err = 1'b1;
        end
    endfunction

    // One accept/response handshake with rsp_ready high; returns what was observed at the accept edge
    task automatic txn(input logic [15:0] addr, input logic we, input logic [63:0] w, input logic [7:0] be,
                       output logic [63:0] rd, output logic err, output logic seen,
                       output logic [NC-1:0] irq_acc, output longint acc);
        req_addr  = addr;
        req_we    = we;
        req_wdata = w;
        req_be    = be;
        req_valid = 1'b1;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        acc       = cyc;
        req_valid = 1'b0;
        seen      = rsp_valid;
        rd        = rsp_rdata;
        err       = rsp_err;
        irq_acc   = timer_irq;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        logic [15:0] addrs [3];
        logic [63:0] rd, erd;
        logic err, eerr, seen;
        logic [NC-1:0] ia;
        longint acc;
        addrs[0] = 16'h4000; addrs[1] = 16'hBFF8; addrs[2] = 16'h0000;
        rst = 1'b1; req_valid = 1'b0; rsp_ready = 1'b1; rtc = 1'b0;
        req_addr = '0; req_we = 1'b0; req_wdata = '0; req_be = '0;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset(cyc);
        if ({req_ready, rsp_valid, rsp_err} !== 3'b100) begin errors++; $display("FAIL reset_ctrl: got %b want 100", {req_ready, rsp_valid, rsp_err}); end
        checks++;
        if (rsp_rdata !== 64'd0) begin errors++; $display("FAIL reset_rdata: got %h want 0", rsp_rdata); end
        checks++;
        if ({timer_irq, ipi} !== '0) begin errors++; $display("FAIL reset_irq: got %b want 0", {timer_irq, ipi}); end
        checks++;
        for (int k = 0; k < 3; k++) begin
            txn(addrs[k], 1'b0, 64'd0, 8'h00, rd, err, seen, ia, acc);
            model_txn(addrs[k], 1'b0, 64'd0, 8'h00, acc, erd, eerr);
            if ({seen, err} !== {1'b1, eerr}) begin errors++; $display("FAIL reset_read_rsp %h: got %b want %b", addrs[k], {seen, err}, {1'b1, eerr}); end
            checks++;
            if (rd !== erd) begin errors++; $display("FAIL reset_read %h: got %h want %h", addrs[k], rd, erd); end
            checks++;
        end
    endtask

    task automatic test_prescale();
        logic [63:0] rd, erd;
        logic err, eerr, seen;
        logic [NC-1:0] ia;
        longint acc;
        txn(16'hBFF8, 1'b1, 64'h10, 8'hFF, rd, err, seen, ia, acc);
        model_txn(16'hBFF8, 1'b1, 64'h10, 8'hFF, acc, erd, eerr);
        repeat (10) @(posedge clk);
        #1;
        txn(16'hBFF8, 1'b0, 64'd0, 8'h00, rd, err, seen, ia, acc);
        model_txn(16'hBFF8, 1'b0, 64'd0, 8'h00, acc, erd, eerr);
        if (rd !== erd) begin errors++; $display("FAIL prescale_mtime: got %h want %h", rd, erd); end
        checks++;
        // be = 0 to mtime is a no-op and must not restart the time base
        txn(16'hBFF8, 1'b1, 64'hDEAD, 8'h00, rd, err, seen, ia, acc);
        model_txn(16'hBFF8, 1'b1, 64'hDEAD, 8'h00, acc, erd, eerr);
        txn(16'hBFF8, 1'b0, 64'd0, 8'h00, rd, err, seen, ia, acc);
        model_txn(16'hBFF8, 1'b0, 64'd0, 8'h00, acc, erd, eerr);
        if (rd !== erd) begin errors++; $display("FAIL prescale_be0: got %h want %h", rd, erd); end
        checks++;
    endtask

    task automatic test_timer();
        logic [63:0] rd, erd;
        logic err, eerr, seen;
        logic [NC-1:0] ia;
        longint acc;
        txn(16'h4010, 1'b1, 64'h20, 8'hFF, rd, err, seen, ia, acc);
        model_txn(16'h4010, 1'b1, 64'h20, 8'hFF, acc, erd, eerr);
        txn(16'hBFF8, 1'b1, 64'h1F, 8'hFF, rd, err, seen, ia, acc);
        model_txn(16'hBFF8, 1'b1, 64'h1F, 8'hFF, acc, erd, eerr);
        for (int k = 0; k < 3; k++) begin
            if (timer_irq !== irq_exp(cyc)) begin errors++; $display("FAIL timer_rise c%0d: got %b want %b", k, timer_irq, irq_exp(cyc)); end
            checks++;
            @(posedge clk); #1;
        end
        if (timer_irq !== 4'b0100) begin errors++; $display("FAIL timer_fired: got %b want 0100", timer_irq); end
        checks++;
        txn(16'h4010, 1'b1, 64'h100, 8'hFF, rd, err, seen, ia, acc);
        model_txn(16'h4010, 1'b1, 64'h100, 8'hFF, acc, erd, eerr);
        if (ia !== irq_exp(acc)) begin errors++; $display("FAIL timer_clear: got %b want %b", ia, irq_exp(acc)); end
        checks++;
    endtask

    task automatic test_msip_backpressure();
        logic [63:0] rd, erd, first;
        logic err, eerr, seen;
        logic [NC-1:0] ia;
        longint acc;
        txn(16'h0018, 1'b1, 64'h1, 8'h01, rd, err, seen, ia, acc);
        model_txn(16'h0018, 1'b1, 64'h1, 8'h01, acc, erd, eerr);
        if (ipi !== ipi_exp()) begin errors++; $display("FAIL msip_set: got %b want %b", ipi, ipi_exp()); end
        checks++;
        txn(16'h0018, 1'b1, 64'h0, 8'h01, rd, err, seen, ia, acc);
        model_txn(16'h0018, 1'b1, 64'h0, 8'h01, acc, erd, eerr);
        if (ipi !== ipi_exp()) begin errors++; $display("FAIL msip_clr: got %b want %b", ipi, ipi_exp()); end
        checks++;
        req_addr = 16'hBFF8; req_we = 1'b0; req_be = 8'h00; req_valid = 1'b1; rsp_ready = 1'b0;
        @(posedge clk); #1;
        acc = cyc;
        req_valid = 1'b0;
        model_txn(16'hBFF8, 1'b0, 64'd0, 8'h00, acc, erd, eerr);
        first = erd;
        for (int k = 0; k < 5; k++) begin
            if ({rsp_valid, req_ready} !== 2'b10) begin errors++; $display("FAIL hold_ctrl c%0d: got %b want 10", k, {rsp_valid, req_ready}); end
            checks++;
            if (rsp_rdata !== first) begin errors++; $display("FAIL hold_rdata c%0d: got %h want %h", k, rsp_rdata, first); end
            checks++;
            @(posedge clk); #1;
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        if ({rsp_valid, req_ready} !== 2'b01) begin errors++; $display("FAIL hold_release: got %b want 01", {rsp_valid, req_ready}); end
        checks++;
    endtask

    task automatic test_wrap_err();
        logic [63:0] rd, erd;
        logic err, eerr, seen;
        logic [NC-1:0] ia;
        longint acc;
        txn(16'hBFF8, 1'b1, '1, 8'hFF, rd, err, seen, ia, acc);
        model_txn(16'hBFF8, 1'b1, '1, 8'hFF, acc, erd, eerr);
        for (int k = 0; k < 2 * P; k++) begin
            if (timer_irq !== irq_exp(cyc)) begin errors++; $display("FAIL wrap_irq c%0d: got %b want %b", k, timer_irq, irq_exp(cyc)); end
            checks++;
            @(posedge clk); #1;
        end
        txn(16'hBFF8, 1'b0, 64'd0, 8'h00, rd, err, seen, ia, acc);
        model_txn(16'hBFF8, 1'b0, 64'd0, 8'h00, acc, erd, eerr);
        if (rd !== erd) begin errors++; $display("FAIL wrap_mtime: got %h want %h", rd, erd); end
        checks++;
        txn(16'h8000, 1'b0, 64'd0, 8'h00, rd, err, seen, ia, acc);
        if ({err, rd} !== {1'b1, 64'd0}) begin errors++; $display("FAIL err_read: got err=%b rd=%h want err=1 rd=0", err, rd); end
        checks++;
        txn(16'h4020, 1'b1, 64'h0, 8'hFF, rd, err, seen, ia, acc);
        if ({err, rd} !== {1'b1, 64'd0}) begin errors++; $display("FAIL err_write: got err=%b rd=%h want err=1 rd=0", err, rd); end
        checks++;
    endtask

    task automatic test_random();
        logic [63:0] rd, erd, w;
        logic [15:0] addr;
        logic [7:0]  be;
        logic err, eerr, seen, we;
        logic [NC-1:0] ia;
        longint acc;
        for (int n = 0; n < 60; n++) begin
            case ($urandom_range(0, 9))
                0, 1, 2: addr = 16'($urandom_range(0, NC - 1) * 8 + $urandom_range(0, 7));
                3, 4, 5: addr = 16'('h4000 + $urandom_range(0, NC - 1) * 8 + $urandom_range(0, 7));
                6, 7:    addr = 16'('hBFF8 + $urandom_range(0, 7));
                8:       addr = 16'($urandom_range(0, 65535));
                default: addr = ($urandom_range(0, 1) != 0) ? 16'h0020 : 16'h4020;
            endcase
            we = 1'($urandom_range(0, 1));
            be = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'hFF;
            w  = {32'($urandom), 32'($urandom)};
            if ($urandom_range(0, 3) == 0) w = 64'($urandom_range(0, 64));
            txn(addr, we, w, be, rd, err, seen, ia, acc);
            model_txn(addr, we, w, be, acc, erd, eerr);
            if ({seen, err} !== {1'b1, eerr}) begin errors++; $display("FAIL rnd_rsp n%0d a=%h: got %b want %b", n, addr, {seen, err}, {1'b1, eerr}); end
            checks++;
            if (rd !== erd) begin errors++; $display("FAIL rnd_rdata n%0d a=%h: got %h want %h", n, addr, rd, erd); end
            checks++;
            if (ia !== irq_exp(acc)) begin errors++; $display("FAIL rnd_irq n%0d: got %b want %b", n, ia, irq_exp(acc)); end
            checks++;
            if (ipi !== ipi_exp()) begin errors++; $display("FAIL rnd_ipi n%0d: got %b want %b", n, ipi, ipi_exp()); end
            checks++;
            repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
        end
    endtask

`ifdef CLINT_RTC_EN
    task automatic test_rtc();
        logic [63:0] rd, erd;
        logic err, eerr, seen;
        logic [NC-1:0] ia;
        longint acc;
        txn(16'hBFF8, 1'b1, 64'h100, 8'hFF, rd, err, seen, ia, acc);
        model_txn(16'hBFF8, 1'b1, 64'h100, 8'hFF, acc, erd, eerr);
        for (int k = 0; k < 3; k++) begin
            rtc = 1'b1;
            repeat (4) @(posedge clk);
            #1;
            rtc = 1'b0;
            repeat (4) @(posedge clk);
            #1;
        end
        m_base = m_base + 64'd3;
        txn(16'hBFF8, 1'b0, 64'd0, 8'h00, rd, err, seen, ia, acc);
        model_txn(16'hBFF8, 1'b0, 64'd0, 8'h00, acc, erd, eerr);
        if (rd !== erd) begin errors++; $display("FAIL rtc_mtime: got %h want %h", rd, erd); end
        checks++;
    endtask
`endif

    task automatic test_reset_mid();
        logic [63:0] rd, erd;
        logic err, eerr, seen;
        logic [NC-1:0] ia;
        longint acc;
        txn(16'h0008, 1'b1, 64'h1, 8'hFF, rd, err, seen, ia, acc);
        model_txn(16'h0008, 1'b1, 64'h1, 8'hFF, acc, erd, eerr);
        req_addr = 16'hBFF8; req_we = 1'b0; req_valid = 1'b1; rsp_ready = 1'b0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        rsp_ready = 1'b1;
        model_reset(cyc);
        if ({rsp_valid, req_ready} !== 2'b01) begin errors++; $display("FAIL rstmid_ctrl: got %b want 01", {rsp_valid, req_ready}); end
        checks++;
        if ({timer_irq, ipi} !== '0) begin errors++; $display("FAIL rstmid_irq: got %b want 0", {timer_irq, ipi}); end
        checks++;
        txn(16'hBFF8, 1'b0, 64'd0, 8'h00, rd, err, seen, ia, acc);
        model_txn(16'hBFF8, 1'b0, 64'd0, 8'h00, acc, erd, eerr);
        if (rd !== erd) begin errors++; $display("FAIL rstmid_mtime: got %h want %h", rd, erd); end
        checks++;
    endtask

    initial begin
        test_reset();
        test_prescale();
        test_timer();
        test_msip_backpressure();
        test_wrap_err();
        test_random();
`ifdef CLINT_RTC_EN
        test_rtc();
`endif
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
